// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared state encoding and defaults for bit_serializer
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10
  } ser_state_e;

  localparam int SER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial front end feeding the sequence detector
// Optional trailing even-parity bit per word when SERIALIZER_PARITY_EN is defined.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = SER_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  ser_state_e       state;
  ser_state_e       state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             accept;
`ifdef SERIALIZER_PARITY_EN
  logic             parity;
`endif

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign accept = din_valid && din_ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    case (state)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == '0) begin
`ifdef SERIALIZER_PARITY_EN
          state_nxt = PARITY;
`else
          din_ready = 1'b1;
          state_nxt = din_valid ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        din_ready = 1'b1;
        state_nxt = din_valid ? SHIFT : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
    if (rst) din_ready = 1'b0;
  end

  // shreg always holds the bits still to be presented after the one on sout,
  // so sout is a true flop loaded from the register head on every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity     <= 1'b0;
`endif
    end else if (accept) begin
      shreg      <= advance(din);
      cnt        <= CW'(WIDTH - 1);
      sout       <= head(din);
      sout_valid <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
      parity     <= ^din;
`endif
    end else if (state == SHIFT && cnt != '0) begin
      shreg      <= advance(shreg);
      cnt        <= cnt - CW'(1);
      sout       <= head(shreg);
      sout_valid <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
    end else if (state == SHIFT) begin
      sout       <= parity;
      sout_valid <= 1'b1;
`endif
    end else begin
      sout       <= 1'b0;
      sout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - bit-queue reference model check of bit_serializer (MSB- and LSB-first)
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       rdy_a, sout_a, sv_a, busy_a;
  logic       rdy_b, sout_b, sv_b, busy_b;

  bit qa[$];
  bit qb[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_a), .sout(sout_a), .sout_valid(sv_a), .busy(busy_a)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_b), .sout(sout_b), .sout_valid(sv_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transmit order of a word as a list of bits, plus parity when compiled in.
  task automatic load(input logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      qa.push_back(((w >> (7 - k)) & 8'd1) != 0);
      qb.push_back(((w >> k) & 8'd1) != 0);
    end
`ifdef SERIALIZER_PARITY_EN
    qa.push_back(($countones(w) % 2) == 1);
    qb.push_back(($countones(w) % 2) == 1);
`endif
  endtask

  task automatic check_all();
    logic exp_rdy;
    exp_rdy = !rst && (qa.size() <= 1);
    chk("a_valid", 32'(sv_a),   32'(qa.size() > 0));
    chk("a_sout",  32'(sout_a), 32'(qa.size() > 0 ? qa[0] : 1'b0));
    chk("a_busy",  32'(busy_a), 32'(qa.size() > 0));
    chk("a_ready", 32'(rdy_a),  32'(exp_rdy));
    chk("b_valid", 32'(sv_b),   32'(qb.size() > 0));
    chk("b_sout",  32'(sout_b), 32'(qb.size() > 0 ? qb[0] : 1'b0));
    chk("b_busy",  32'(busy_b), 32'(qb.size() > 0));
    chk("b_ready", 32'(rdy_b),  32'(exp_rdy));
  endtask

  // One clock: a word is taken when offered while at most one bit remains queued.
  task automatic tick();
    bit acc;
    logic [7:0] w;
    acc = din_valid && !rst && (qa.size() <= 1);
    w   = din;
    @(posedge clk);
    if (qa.size() > 0) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
    end
    if (acc) load(w);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    din = 8'h00;
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    #1 check_all();

    @(negedge clk);
    din = 8'hB0; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (9) tick();

    din = 8'h0B; din_valid = 1'b1;
    tick();
    din = 8'hB0;
    repeat (8) tick();
    din_valid = 1'b0;
    repeat (9) tick();

    din = 8'h0D; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (2) tick();
    din = 8'hFF; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (7) tick();

    din = 8'hB0; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    qa.delete();
    qb.delete();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    din = 8'h01; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (9) tick();

    for (int i = 0; i < 400; i++) begin
      din = 8'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      tick();
    end
    din_valid = 1'b0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the sequence-detector FSM. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `sout`. The detector's serial input `in` is driven directly from `sout`, and `sout_valid` marks the cycles the detector must treat as real data. Back-to-back words produce a gapless bit stream, so patterns spanning a word boundary are still detected.

## Interface
- `WIDTH`, 8: data word width; legal range 2..32.
- `MSB_FIRST`, 1: 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `din`  input  WIDTH  parallel word; sampled only on an accepted handshake.
- `din_valid`  input  1  upstream has a word on `din`.
- `din_ready`  output  1  block can accept a word this cycle (combinational).
- `sout`  output  1  serial bit, registered; feeds detector `in`.
- `sout_valid`  output  1  `sout` carries a live bit this cycle, registered.
- `busy`  output  1  a word (or its parity bit) is still being shifted.

## Operation
- States: IDLE, SHIFT, and PARITY (PARITY exists only with the macro).
- Handshake: a word is accepted on a rising edge where `din_valid && din_ready`. `din` is copied into the shift register and the bit counter is set to WIDTH-1.
- `din_ready`:
  - 1 in IDLE.
  - 1 in the last-bit cycle of SHIFT (counter == 0) when parity is compiled out.
  - 1 in the PARITY cycle when parity is compiled in.
  - 0 otherwise.
  - Forced 0 while `rst` is high.
- Transitions:
  - IDLE → SHIFT on accept.
  - SHIFT, counter > 0: stay, decrement the counter, shift by one.
  - SHIFT, counter == 0: go to PARITY (if enabled). Otherwise go to SHIFT on a new accept, or IDLE if none.
  - PARITY → SHIFT on accept, else IDLE.
- `sout` source:
  - SHIFT: the current head of the shift register (MSB when MSB_FIRST=1, LSB otherwise).
  - PARITY: the parity bit.
  - IDLE: holds 0.
- `sout_valid` = 1 in SHIFT and PARITY, 0 in IDLE.
- `busy` = (state != IDLE).
- `din_valid` without `din_ready`: no effect. The upstream must hold the word; no data is lost or overwritten.
- `din` changing mid-word has no effect. Only the shift register copy is used.
- Counter width is $clog2(WIDTH). It never wraps below 0; reaching 0 forces a transition.

## Timing
- Reset values (async, immediate): state=IDLE, `sout`=0, `sout_valid`=0, `busy`=0, shift register=0, counter=0, parity accumulator=0.
- Latency: a word accepted at edge N presents its first bit on `sout` at edge N (visible in cycle N+1). Bit k of the transmit order appears in cycle N+1+k.
- Per-word duration: WIDTH cycles of `sout_valid`, or WIDTH+1 with parity.
- Back-to-back: an accept in the last-bit (or parity) cycle starts the next word's first bit in the very next cycle, with no `sout_valid` gap.
- Reset asserted mid-word: the partial word is dropped and outputs return to reset values asynchronously. After deassertion, the first accept can occur at the first rising edge.
- Throughput: one word per WIDTH (or WIDTH+1) cycles sustained.

## Configuration
- `SERIALIZER_PARITY_EN` defined:
  - Adds the PARITY state.
  - After the data bits, one extra bit equal to even parity of the word (XOR of all `din` bits) is emitted with `sout_valid`=1.
  - `din_ready` rises in the parity cycle instead of the last data cycle.
- `SERIALIZER_PARITY_EN` undefined: no PARITY state and no parity logic. Words are exactly WIDTH bits.

## Structure
- Shared package `serializer_pkg`:
  - state enum (IDLE=2'b00, SHIFT=2'b01, PARITY=2'b10), held in a 2-bit register.
  - default width constant `SER_DEFAULT_WIDTH = 8`.
- Single module; no sub-module is warranted. Shift register, counter and parity accumulator stay inline.

## Test plan
- Reset release, WIDTH=8, MSB_FIRST=1: `din`=8'hB0 accepted → `sout` = 1,0,1,1,0,0,0,0 over 8 cycles with `sout_valid`=1. A detector attached on `sout` asserts `q` after the 4th bit. `busy` drops the cycle after the last bit.
- Back-to-back 8'h0B then 8'hB0, `din_valid` held high → exactly 16 consecutive `sout_valid` cycles. `din_ready` is high only in cycles 0, 8 and 16 relative to the first accept.
- MSB_FIRST=0, `din`=8'h0D → `sout` = 1,0,1,1,0,0,0,0.
- `din_valid` pulsed while `busy`=1 and `din_ready`=0 with `din`=8'hFF → ignored; the in-flight word streams unchanged.
- `rst` asserted at bit 3 of 8'hB0 → `sout`=0, `sout_valid`=0 and `busy`=0 immediately, before the next edge. After release, `din`=8'h01 streams correctly.
- With `SERIALIZER_PARITY_EN`, `din`=8'hB0 → 9 valid bits, ninth bit = 1. `din`=8'h03 → ninth bit = 0.
